// File: rtl/inventario_dual_stock_pkg.sv
// Shared types and helpers for the dual-product stock keeper.
package inventario_pkg;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_LOAD,
    RS_ACK
  } rs_state_t;

  localparam logic PROD_A = 1'b0;
  localparam logic PROD_B = 1'b1;

  // Widened add with an optional simultaneous decrement, clamped to max; an empty sum never wraps.
  function automatic int unsigned sat_add(input int unsigned cnt,
                                          input int unsigned qty,
                                          input logic        dec,
                                          input int unsigned max);
    int unsigned sum;
    sum = cnt + qty;
    if (dec && (sum != 0)) sum = sum - 1;
    if (sum > max) sum = max;
    return sum;
  endfunction

endpackage

// File: rtl/inventario_dual_stock_stock_counter.sv
// One product's stock: sale edge detect, saturating counter, in-stock/low decode, underflow pulse.
module stock_counter
  import inventario_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int INIT      = 5,
  parameter int MAX_STOCK = 15,
  parameter int LOW_THR   = 2
) (
  input  logic             clk1,
  input  logic             reset1,
  input  logic             sale_lvl,
  input  logic             load,
  input  logic [CNT_W-1:0] qty,
  output logic [CNT_W-1:0] cnt,
  output logic             in_stock,
  output logic             low,
  output logic             under,
  output logic             sold
);

  logic prev;
  logic sale;
  logic empty_now;

  assign sale = sale_lvl & ~prev;

  // During a load the restock quantity can cover the sale, so only an empty sum underflows.
  assign empty_now = load ? ((cnt == '0) && (qty == '0)) : (cnt == '0);
  assign sold      = sale & ~empty_now;

  assign in_stock = (cnt != '0);
  assign low      = (cnt != '0) && (cnt <= CNT_W'(LOW_THR));

  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      prev  <= 1'b0;
      cnt   <= CNT_W'(INIT);
      under <= 1'b0;
    end else begin
      prev  <= sale_lvl;
      under <= sale & empty_now;
      if (load)
        cnt <= CNT_W'(sat_add(32'(cnt), 32'(qty), sale, 32'(MAX_STOCK)));
      else if (sold)
        cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/inventario_dual_stock.sv
// Dual-product stock keeper: restock handshake FSM feeding two stock counters.
// Optional macro SALES_TALLY_EN builds saturating per-product sales tallies.
module inventario_dual_stock
  import inventario_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int INIT_A    = 5,
  parameter int INIT_B    = 5,
  parameter int MAX_STOCK = 15,
  parameter int LOW_THR   = 2
) (
  input  logic             clk1,
  input  logic             reset1,
  input  logic             L,
  input  logic             L2,
  input  logic             restock_req,
  input  logic             restock_sel,
  input  logic [CNT_W-1:0] restock_qty,
  output logic             restock_ack,
  output logic             E,
  output logic             E2,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             low_a,
  output logic             low_b,
  output logic             err_under,
  output logic [7:0]       sales_a,
  output logic [7:0]       sales_b
);

  rs_state_t        state;
  logic             sel_q;
  logic [CNT_W-1:0] qty_q;
  logic             load_a;
  logic             load_b;
  logic             under_a;
  logic             under_b;
  logic             sold_a;
  logic             sold_b;

  // Ack is registered one cycle into RS_ACK and released on the edge that sees req low.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      state       <= RS_IDLE;
      sel_q       <= PROD_A;
      qty_q       <= '0;
      restock_ack <= 1'b0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (restock_req) begin
            sel_q <= restock_sel;
            qty_q <= restock_qty;
            state <= RS_LOAD;
          end
        end
        RS_LOAD: state <= RS_ACK;
        RS_ACK: begin
          if (!restock_req) begin
            restock_ack <= 1'b0;
            state       <= RS_IDLE;
          end else begin
            restock_ack <= 1'b1;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  assign load_a = (state == RS_LOAD) && (sel_q == PROD_A);
  assign load_b = (state == RS_LOAD) && (sel_q == PROD_B);

  stock_counter #(
    .CNT_W(CNT_W), .INIT(INIT_A), .MAX_STOCK(MAX_STOCK), .LOW_THR(LOW_THR)
  ) u_stock_a (
    .clk1(clk1), .reset1(reset1), .sale_lvl(L), .load(load_a), .qty(qty_q),
    .cnt(cnt_a), .in_stock(E), .low(low_a), .under(under_a), .sold(sold_a)
  );

  stock_counter #(
    .CNT_W(CNT_W), .INIT(INIT_B), .MAX_STOCK(MAX_STOCK), .LOW_THR(LOW_THR)
  ) u_stock_b (
    .clk1(clk1), .reset1(reset1), .sale_lvl(L2), .load(load_b), .qty(qty_q),
    .cnt(cnt_b), .in_stock(E2), .low(low_b), .under(under_b), .sold(sold_b)
  );

  assign err_under = under_a | under_b;

`ifdef SALES_TALLY_EN
  // Tallies count only accepted sales and hold at 255.
  always_ff @(posedge clk1 or posedge reset1) begin
    if (reset1) begin
      sales_a <= 8'd0;
      sales_b <= 8'd0;
    end else begin
      if (sold_a && (sales_a != 8'hFF)) sales_a <= sales_a + 8'd1;
      if (sold_b && (sales_b != 8'hFF)) sales_b <= sales_b + 8'd1;
    end
  end
`else
  logic unused_sold;
  assign unused_sold = sold_a ^ sold_b;
  assign sales_a     = 8'd0;
  assign sales_b     = 8'd0;
`endif

endmodule

// File: tb/tb_inventario_dual_stock.sv
// Directed self-checking bench for inventario_dual_stock with hand-computed expectations.
module tb_inventario_dual_stock;

  logic       clk1;
  logic       reset1;
  logic       L;
  logic       L2;
  logic       restock_req;
  logic       restock_sel;
  logic [3:0] restock_qty;
  logic       restock_ack;
  logic       E;
  logic       E2;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       low_a;
  logic       low_b;
  logic       err_under;
  logic [7:0] sales_a;
  logic [7:0] sales_b;

  int total;
  int bad;

  inventario_dual_stock dut (
    .clk1(clk1), .reset1(reset1), .L(L), .L2(L2),
    .restock_req(restock_req), .restock_sel(restock_sel), .restock_qty(restock_qty),
    .restock_ack(restock_ack), .E(E), .E2(E2), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .low_a(low_a), .low_b(low_b), .err_under(err_under),
    .sales_a(sales_a), .sales_b(sales_b)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One active edge, then park on the falling edge where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic applyStimulus(input logic a, input logic b);
    L  = a;
    L2 = b;
    tick();
    L  = 1'b0;
    L2 = 1'b0;
    tick();
  endtask

  task automatic doReset();
    L = 1'b0; L2 = 1'b0; restock_req = 1'b0; restock_sel = 1'b0; restock_qty = 4'd0;
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset1 = 1'b1;
    L = 1'b0; L2 = 1'b0; restock_req = 1'b0; restock_sel = 1'b0; restock_qty = 4'd0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_cnt_a", 32'(cnt_a), 32'd5);
    checkOutput("rst_cnt_b", 32'(cnt_b), 32'd5);
    checkOutput("rst_E_E2", 32'({E, E2}), 32'd3);
    checkOutput("rst_low", 32'({low_a, low_b}), 32'd0);
    checkOutput("rst_ack", 32'(restock_ack), 32'd0);
    checkOutput("rst_err", 32'(err_under), 32'd0);
    reset1 = 1'b0;
    tick();

    // Five single-cycle sales drain A
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_4", 32'(cnt_a), 32'd4);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_3", 32'(cnt_a), 32'd3);
    checkOutput("drain_3_low", 32'(low_a), 32'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_2", 32'(cnt_a), 32'd2);
    checkOutput("drain_2_low", 32'(low_a), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_1", 32'(cnt_a), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("drain_0", 32'(cnt_a), 32'd0);
    checkOutput("drain_0_E", 32'(E), 32'd0);
    checkOutput("drain_0_low", 32'(low_a), 32'd0);
    checkOutput("drain_cnt_b", 32'(cnt_b), 32'd5);

    // Sale on empty A pulses err_under for exactly one cycle
    L = 1'b1;
    tick();
    checkOutput("under_pulse", 32'(err_under), 32'd1);
    checkOutput("under_cnt", 32'(cnt_a), 32'd0);
    L = 1'b0;
    tick();
    checkOutput("under_clear", 32'(err_under), 32'd0);

    // Level held four cycles is one sale
    doReset();
    L = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("held_once", 32'(cnt_a), 32'd4);
    L = 1'b0;
    tick();
    checkOutput("held_after", 32'(cnt_a), 32'd4);

    // Restock B by 7, then by 9 into saturation
    doReset();
    restock_req = 1'b1; restock_sel = 1'b1; restock_qty = 4'd7;
    tick();
    checkOutput("rsB_e0_cnt", 32'(cnt_b), 32'd5);
    checkOutput("rsB_e0_ack", 32'(restock_ack), 32'd0);
    tick();
    checkOutput("rsB_e1_cnt", 32'(cnt_b), 32'd12);
    checkOutput("rsB_e1_ack", 32'(restock_ack), 32'd0);
    tick();
    checkOutput("rsB_e2_ack", 32'(restock_ack), 32'd1);
    checkOutput("rsB_cnt_a", 32'(cnt_a), 32'd5);
    restock_req = 1'b0;
    tick();
    checkOutput("rsB_ack_drop", 32'(restock_ack), 32'd0);
    tick();
    restock_req = 1'b1; restock_qty = 4'd9;
    tick();
    tick();
    checkOutput("rsB_sat", 32'(cnt_b), 32'd15);
    tick();
    checkOutput("rsB_sat_ack", 32'(restock_ack), 32'd1);
    restock_req = 1'b0;
    tick();
    tick();

    // Zero-quantity restock completes and leaves A alone
    restock_req = 1'b1; restock_sel = 1'b0; restock_qty = 4'd0;
    tick();
    tick();
    tick();
    checkOutput("qty0_ack", 32'(restock_ack), 32'd1);
    checkOutput("qty0_cnt", 32'(cnt_a), 32'd5);
    restock_req = 1'b0;
    tick();
    tick();

    // Empty A restocked by 3 while a sale lands in the load cycle
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("pre_load_a", 32'(cnt_a), 32'd0);
    restock_req = 1'b1; restock_sel = 1'b0; restock_qty = 4'd3;
    tick();
    L = 1'b1;
    tick();
    checkOutput("loadsale_cnt", 32'(cnt_a), 32'd2);
    checkOutput("loadsale_E", 32'(E), 32'd1);
    checkOutput("loadsale_err", 32'(err_under), 32'd0);
    L = 1'b0;
    tick();
    checkOutput("loadsale_ack", 32'(restock_ack), 32'd1);
    restock_req = 1'b0;
    tick();

    // Simultaneous sales on both products
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_a", 32'(cnt_a), 32'd1);
    checkOutput("both_b", 32'(cnt_b), 32'd14);

    // Reset while the FSM sits in RS_LOAD discards the restock
    restock_req = 1'b1; restock_sel = 1'b0; restock_qty = 4'd4;
    tick();
    reset1 = 1'b1;
    #1;
    checkOutput("midrst_ack", 32'(restock_ack), 32'd0);
    checkOutput("midrst_cnt", 32'(cnt_a), 32'd5);
    restock_req = 1'b0;
    tick();
    reset1 = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("midrst_no_load", 32'(cnt_a), 32'd5);
    checkOutput("midrst_idle_ack", 32'(restock_ack), 32'd0);

    // Sales tally after three accepted A sales
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("tally_cnt_a", 32'(cnt_a), 32'd2);
`ifdef SALES_TALLY_EN
    checkOutput("tally_a", 32'(sales_a), 32'd3);
`else
    checkOutput("tally_a", 32'(sales_a), 32'd0);
`endif
    checkOutput("tally_b", 32'(sales_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
